// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial-to-parallel receive stage for a framed 1-bit stream.
//
// It collects WIDTH valid bits, starting at a bit flagged by ser_sof, and
// presents each completed word on a registered valid/ready output.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   ser_in              serial data bit
//   ser_valid           ser_in carries a bit this cycle
//   ser_sof             this valid bit is the first bit of a word
//   dout, dout_valid    assembled word and its valid flag (registered)
//   dout_ready          consumer accepts dout when dout_valid && dout_ready
//   frame_err           one-cycle pulse: ser_sof arrived mid-word
//   overrun             one-cycle pulse: a completed word was dropped
//
// MSB_FIRST=1 puts the first received bit in dout[WIDTH-1].
// MSB_FIRST=0 puts it in dout[0].
module sipo_frame_rx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             ser_sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic [WIDTH-1:0] w_shift;      // r_sreg shifted by one with ser_in inserted
    logic [WIDTH-1:0] w_first;      // a fresh word holding only ser_in
    logic [WIDTH-1:0] w_next_sreg;
    logic [CW-1:0]    w_next_cnt;
    logic             w_start;
    logic             w_accept;
    logic             w_complete;
    logic             w_ferr;

    always_comb begin
        w_shift = '0;
        w_first = '0;
        if (MSB_FIRST) begin
            w_shift[0] = ser_in;
            w_first[0] = ser_in;
            for (int i = 1; i < int'(WIDTH); i++) begin
                w_shift[i] = r_sreg[i-1];
            end
        end else begin
            w_shift[WIDTH-1] = ser_in;
            w_first[WIDTH-1] = ser_in;
            for (int i = 0; i < int'(WIDTH) - 1; i++) begin
                w_shift[i] = r_sreg[i+1];
            end
        end

        w_start     = ser_valid && ser_sof;
        // In IDLE only a start bit is taken; stray bits are discarded silently.
        w_accept    = ser_valid && (ser_sof || (r_state == StShift));
        w_ferr      = w_start && (r_state == StShift);
        w_next_sreg = w_start ? w_first : w_shift;
        w_next_cnt  = w_start ? CW'(1) : r_cnt + CW'(1);
        w_complete  = w_accept && (w_next_cnt == CW'(WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_sreg       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;

            if (w_accept) begin
                r_sreg <= w_next_sreg;
                if (w_complete) begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                end else begin
                    r_state <= StShift;
                    r_cnt   <= w_next_cnt;
                end
            end

            // An accept and a reload in the same cycle keep dout_valid high.
            if (w_complete) begin
                if (!r_dout_valid || dout_ready) begin
                    r_dout       <= w_next_sreg;
                    r_dout_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Testbench for sipo_frame_rx. It runs an MSB-first instance and an
// LSB-first instance from the same stimulus. It compares both against a
// queue-based model on every cycle, and also checks literal word values.
module tb_sipo_frame_rx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ser_in, ser_valid, ser_sof, dout_ready;
    logic [W-1:0] dout_m, dout_l;
    logic         dv_m, dv_l, fe_m, fe_l, ov_m, ov_l;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .ser_sof    (ser_sof),
        .dout       (dout_m),
        .dout_valid (dv_m),
        .dout_ready (dout_ready),
        .frame_err  (fe_m),
        .overrun    (ov_m)
    );

    sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .ser_sof    (ser_sof),
        .dout       (dout_l),
        .dout_valid (dv_l),
        .dout_ready (dout_ready),
        .frame_err  (fe_l),
        .overrun    (ov_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: collect bits of the current frame in a queue. When WIDTH bits
    // are present, build the word arithmetically for both bit orders.
    bit     q[$];
    bit     in_word;
    int     e_dout_m, e_dout_l;
    bit     e_dv, e_fe, e_ov;

    always @(posedge clk) begin
        int  wm, wl;
        bit  comp;
        if (rst) begin
            q.delete();
            in_word  = 1'b0;
            e_dout_m = 0;
            e_dout_l = 0;
            e_dv     = 1'b0;
            e_fe     = 1'b0;
            e_ov     = 1'b0;
        end else begin
            comp = 1'b0;
            e_fe = 1'b0;
            e_ov = 1'b0;
            if (ser_valid) begin
                if (ser_sof) begin
                    if (in_word) e_fe = 1'b1;
                    q.delete();
                    in_word = 1'b1;
                    q.push_back(ser_in);
                end else if (in_word) begin
                    q.push_back(ser_in);
                end
            end
            if (in_word && q.size() == W) begin
                comp = 1'b1;
                wm   = 0;
                wl   = 0;
                for (int k = 0; k < W; k++) begin
                    wm = wm + (int'(q[k]) << (W - 1 - k));
                    wl = wl + (int'(q[k]) << k);
                end
                q.delete();
                in_word = 1'b0;
            end
            if (comp) begin
                if (!e_dv || dout_ready) begin
                    e_dout_m = wm;
                    e_dout_l = wl;
                    e_dv     = 1'b1;
                end else begin
                    e_ov = 1'b1;
                end
            end else if (e_dv && dout_ready) begin
                e_dv = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model dout msb", 32'(dout_m), 32'(e_dout_m));
            chk("model dout lsb", 32'(dout_l), 32'(e_dout_l));
            chk("model dout_valid msb", 32'(dv_m), 32'(e_dv));
            chk("model dout_valid lsb", 32'(dv_l), 32'(e_dv));
            chk("model frame_err", 32'({fe_m, fe_l}), 32'({e_fe, e_fe}));
            chk("model overrun", 32'({ov_m, ov_l}), 32'({e_ov, e_ov}));
        end
    end

    // Apply one cycle of inputs; return 1 time unit after the sampling edge.
    task automatic cyc(input logic v, input logic b, input logic s, input logic r);
        ser_valid  = v;
        ser_in     = b;
        ser_sof    = s;
        dout_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Send four bits back-to-back, seq[3] first, with ser_sof on the first bit.
    task automatic send_word(input logic [3:0] seq, input logic r);
        logic [3:0] s;
        s = seq;
        cyc(1'b1, s[3], 1'b1, r);
        cyc(1'b1, s[2], 1'b0, r);
        cyc(1'b1, s[1], 1'b0, r);
        cyc(1'b1, s[0], 1'b0, r);
    endtask

    initial begin
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);  // ser_* is ignored during reset
        chk("reset dout", 32'({dout_m, dout_l}), 32'h0);
        chk("reset flags", 32'({dv_m, dv_l, fe_m, fe_l, ov_m, ov_l}), 32'h0);
        chk_en = 1'b1;
        rst    = 1'b0;

        // Basic word: bits 1,1,0,1.
        send_word(4'b1101, 1'b1);
        chk("basic dout msb", 32'(dout_m), 32'hD);
        chk("basic dout lsb", 32'(dout_l), 32'hB);
        chk("basic valid", 32'(dv_m), 32'h1);
        chk("basic flags", 32'({fe_m, ov_m}), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic valid one cycle", 32'(dv_m), 32'h0);

        // Same word with a 3-cycle gap between bits 2 and 3.
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("gap not yet complete", 32'(dv_m), 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("gap dout msb", 32'(dout_m), 32'hD);
        chk("gap valid", 32'(dv_m), 32'h1);

        // Stray bit in IDLE is discarded, then LSB-first words.
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        send_word(4'b1000, 1'b1);
        chk("lsb 1000", 32'(dout_l), 32'h1);
        chk("msb 1000", 32'(dout_m), 32'h8);
        send_word(4'b1101, 1'b1);
        chk("lsb 1101", 32'(dout_l), 32'hB);

        // Framing error: 1,0 then restart with 0,1,1,0.
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("frame_err pulse", 32'({fe_m, fe_l}), 32'h3);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("frame_err single", 32'(fe_m), 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("restart dout msb", 32'(dout_m), 32'h6);
        chk("restart dout lsb", 32'(dout_l), 32'h6);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun: two back-to-back words with the consumer stalled.
        send_word(4'b1010, 1'b0);
        chk("ovr first word", 32'(dout_m), 32'hA);
        send_word(4'b0101, 1'b0);
        chk("ovr pulse", 32'({ov_m, ov_l}), 32'h3);
        chk("ovr dout kept", 32'(dout_m), 32'hA);
        chk("ovr valid kept", 32'(dv_m), 32'h1);
        // Accept the held word in the same cycle the next word completes.
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("ovr single pulse", 32'(ov_m), 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("reload dout msb", 32'(dout_m), 32'h5);
        chk("reload dout lsb", 32'(dout_l), 32'hA);
        chk("reload valid", 32'(dv_m), 32'h1);
        chk("reload no overrun", 32'(ov_m), 32'h0);

        // Reset mid-word while a word is still held.
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        chk("midreset valid", 32'(dv_m), 32'h0);
        chk("midreset dout", 32'({dout_m, dout_l}), 32'h0);
        send_word(4'b0011, 1'b1);
        chk("post reset dout msb", 32'(dout_m), 32'h3);
        chk("post reset dout lsb", 32'(dout_l), 32'hC);
        chk("post reset flags", 32'({fe_m, ov_m}), 32'h0);

        // Mixed traffic checked by the model only.
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom % 4) != 0, 1'($urandom), ($urandom % 5) == 0, 1'($urandom));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
